btn_cond: RTL and testbench

- Multi-button conditioner upstream of the clock controller; replaces raw switch inputs with clean, single-clk-cycle events.
- Per button:
  - 2-flop synchronizer
  - sampled-majority-free debounce (N consecutive agreeing samples)
  - press/release edge pulses
  - long-press detection with auto-repeat, so the controller's setup-mode increment can fast-advance while a button is held
- Buttons are active-low at the pins (released = 1).

---
 rtl/btn_cond.sv | 173 +++++++++++++++++
 tb/tb_btn_cond.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cond.sv
// Multi-button conditioner: synchronizes and debounces raw active-low switches,
// then emits press/release edges and long-press / auto-repeat strobes per channel.
module btn_cond #(
   parameter int NUM_BTN        = 3,
   parameter int SAMPLE_DIV     = 500000,
   parameter int DEB_CNT        = 4,
   parameter int HOLD_SAMPLES   = 100,
   parameter int REPEAT_SAMPLES = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] i_sw,
   output logic [NUM_BTN-1:0] o_level,
   output logic [NUM_BTN-1:0] o_press,
   output logic [NUM_BTN-1:0] o_release,
   output logic [NUM_BTN-1:0] o_long,
   output logic [NUM_BTN-1:0] o_repeat,
   output logic [NUM_BTN-1:0] o_event
);

   // state   | meaning
   // IDLE    | debounced level low, no hold timing
   // HELD    | pressed, counting ticks toward long-press
   // REPEAT  | long-press fired, pulsing o_repeat every REPEAT_SAMPLES ticks

   localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam int HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
   localparam int RW = (REPEAT_SAMPLES > 1) ? $clog2(REPEAT_SAMPLES) : 1;

   localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SAMPLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_SAMPLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HELD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   logic [NUM_BTN-1:0] sync1_q;
   logic [NUM_BTN-1:0] sync2_q;
   logic [SW-1:0]      samp_cnt_q;
   logic               tick;
   logic [NUM_BTN-1:0] raw_p;

   logic [DW-1:0]      deb_cnt_q [NUM_BTN];
   logic [DW-1:0]      deb_cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] level_q;
   logic [NUM_BTN-1:0] level_d;
   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] fall;

   state_t             state_q    [NUM_BTN];
   logic [HW-1:0]      hold_cnt_q [NUM_BTN];
   logic [RW-1:0]      rep_cnt_q  [NUM_BTN];

   logic [NUM_BTN-1:0] press_q;
   logic [NUM_BTN-1:0] release_q;
   logic [NUM_BTN-1:0] long_q;
   logic [NUM_BTN-1:0] repeat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '1;
         sync2_q    <= '1;
         samp_cnt_q <= '0;
      end else begin
         sync1_q    <= i_sw;
         sync2_q    <= sync1_q;
         samp_cnt_q <= tick ? '0 : samp_cnt_q + SW'(1);
      end
   end

   assign tick  = (samp_cnt_q == SAMP_LAST);
   assign raw_p = ~sync2_q;

   // A level change needs DEB_CNT consecutive differing samples; any agreeing sample restarts the run.
   always_comb begin
      level_d = level_q;
      rise    = '0;
      fall    = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         if (tick) begin
            if (raw_p[i] != level_q[i]) begin
               if (deb_cnt_q[i] == DEB_LAST) begin
                  deb_cnt_d[i] = '0;
                  level_d[i]   = ~level_q[i];
                  rise[i]      = ~level_q[i];
                  fall[i]      = level_q[i];
               end else begin
                  deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
               end
            end else begin
               deb_cnt_d[i] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         repeat_q  <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            deb_cnt_q[i]  <= '0;
            state_q[i]    <= ST_IDLE;
            hold_cnt_q[i] <= '0;
            rep_cnt_q[i]  <= '0;
         end
      end else begin
         level_q   <= level_d;
         press_q   <= rise;
         release_q <= fall;
         long_q    <= '0;
         repeat_q  <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
            // A release on the same tick as an expiry suppresses the long/repeat pulse.
            if (fall[i]) begin
               state_q[i]    <= ST_IDLE;
               hold_cnt_q[i] <= '0;
               rep_cnt_q[i]  <= '0;
            end else if (tick) begin
               case (state_q[i])
                  ST_IDLE: begin
                     if (rise[i]) begin
                        state_q[i]    <= ST_HELD;
                        hold_cnt_q[i] <= '0;
                     end
                  end
                  ST_HELD: begin
                     if (hold_cnt_q[i] == HOLD_LAST) begin
                        long_q[i]     <= 1'b1;
                        state_q[i]    <= ST_REPEAT;
                        hold_cnt_q[i] <= '0;
                        rep_cnt_q[i]  <= '0;
                     end else begin
                        hold_cnt_q[i] <= hold_cnt_q[i] + HW'(1);
                     end
                  end
                  ST_REPEAT: begin
                     if (rep_cnt_q[i] == REP_LAST) begin
                        repeat_q[i]  <= 1'b1;
                        rep_cnt_q[i] <= '0;
                     end else begin
                        rep_cnt_q[i] <= rep_cnt_q[i] + RW'(1);
                     end
                  end
                  default: begin
                     state_q[i]    <= ST_IDLE;
                     hold_cnt_q[i] <= '0;
                     rep_cnt_q[i]  <= '0;
                  end
               endcase
            end
         end
      end
   end

   assign o_level   = level_q;
   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_long    = long_q;
   assign o_repeat  = repeat_q;
   assign o_event   = press_q | repeat_q;

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with a short sample period so debounce, hold and
// repeat timing can be stepped tick by tick.
module tb_btn_cond;
   localparam int NB = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] i_sw = '1;
   logic [NB-1:0] o_level, o_press, o_release, o_long, o_repeat, o_event;

   int n_pass = 0;
   int n_chk  = 0;
   int cnt_m  = 0;
   int n_press [NB];
   int n_rel   [NB];
   int n_long  [NB];
   int n_rep   [NB];
   int n_evt   [NB];

   btn_cond #(
      .NUM_BTN(3), .SAMPLE_DIV(4), .DEB_CNT(3), .HOLD_SAMPLES(5), .REPEAT_SAMPLES(2)
   ) dut (
      .clk(clk), .rst(rst), .i_sw(i_sw),
      .o_level(o_level), .o_press(o_press), .o_release(o_release),
      .o_long(o_long), .o_repeat(o_repeat), .o_event(o_event)
   );

   always #5 clk = ~clk;

   // Sample-period model and pulse counters.
   always @(posedge clk) begin
      if (rst) cnt_m <= 0;
      else     cnt_m <= (cnt_m == 3) ? 0 : cnt_m + 1;
      for (int i = 0; i < NB; i++) begin
         if (o_press[i])   n_press[i] <= n_press[i] + 1;
         if (o_release[i]) n_rel[i]   <= n_rel[i] + 1;
         if (o_long[i])    n_long[i]  <= n_long[i] + 1;
         if (o_repeat[i])  n_rep[i]   <= n_rep[i] + 1;
         if (o_event[i])   n_evt[i]   <= n_evt[i] + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog");
   end

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   // Returns 1 ns after the next sample-tick edge.
   task automatic step_tick();
      do @(negedge clk); while (cnt_m != 3);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [NB-1:0] exp_l;
      rst  = 1'b1;
      i_sw = 3'b000;
      repeat (3) begin
         step_clk();
         n_chk++;
         if ({o_level, o_press, o_release, o_long, o_repeat, o_event} !== 18'd0)
            $display("FAIL reset_outputs: got %b want 0",
                     {o_level, o_press, o_release, o_long, o_repeat, o_event});
         else n_pass++;
      end
      rst = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         step_tick();
         exp_l = (t == 3) ? 3'b111 : 3'b000;
         n_chk++;
         if ({o_level, o_press, o_event} !== {exp_l, exp_l, exp_l})
            $display("FAIL reset_repress t%0d: got lvl/press/evt %b want %b", t,
                     {o_level, o_press, o_event}, {exp_l, exp_l, exp_l});
         else n_pass++;
      end
      step_clk();
      n_chk++;
      if ({o_level, o_press, o_event} !== {3'b111, 3'b000, 3'b000})
         $display("FAIL reset_press_width: got %b want %b", {o_level, o_press, o_event},
                  {3'b111, 3'b000, 3'b000});
      else n_pass++;
      i_sw = 3'b111;
      for (int t = 1; t <= 3; t++) begin
         step_tick();
         exp_l = (t == 3) ? 3'b000 : 3'b111;
         n_chk++;
         if ({o_level, o_release, o_long} !== {exp_l, ~exp_l, 3'b000})
            $display("FAIL reset_release t%0d: got lvl/rel/long %b want %b", t,
                     {o_level, o_release, o_long}, {exp_l, ~exp_l, 3'b000});
         else n_pass++;
      end
   endtask

   task automatic test_clean_press();
      int s_p, s_r, s_l, s_e;
      logic [3:0] exp_v;
      step_tick();
      s_p = n_press[0]; s_r = n_rel[0]; s_l = n_long[0]; s_e = n_evt[0];
      i_sw = 3'b110;
      for (int t = 1; t <= 8; t++) begin
         step_tick();
         exp_v = {(t >= 3 && t < 7), (t == 3), (t == 7), 1'b0};
         n_chk++;
         if ({o_level[0], o_press[0], o_release[0], o_long[0]} !== exp_v)
            $display("FAIL clean_press t%0d: got lvl/press/rel/long %b want %b", t,
                     {o_level[0], o_press[0], o_release[0], o_long[0]}, exp_v);
         else n_pass++;
         if (t == 4) i_sw = 3'b111;
      end
      step_tick();
      n_chk++;
      if ({n_press[0] - s_p, n_rel[0] - s_r, n_long[0] - s_l, n_evt[0] - s_e} !== {32'd1, 32'd1, 32'd0, 32'd1})
         $display("FAIL clean_counts: got press %0d rel %0d long %0d evt %0d want 1 1 0 1",
                  n_press[0] - s_p, n_rel[0] - s_r, n_long[0] - s_l, n_evt[0] - s_e);
      else n_pass++;
   endtask

   task automatic test_bounce();
      int s_p, s_r, s_e;
      step_tick();
      s_p = n_press[1]; s_r = n_rel[1]; s_e = n_evt[1];
      for (int k = 0; k < 12; k++) begin
         i_sw[1] = ~i_sw[1];
         repeat (5) begin
            step_clk();
            n_chk++;
            if (o_level[1] !== 1'b0)
               $display("FAIL bounce_level k%0d: got %b want 0", k, o_level[1]);
            else n_pass++;
         end
      end
      repeat (4) step_tick();
      n_chk++;
      if ({n_press[1] - s_p, n_rel[1] - s_r, n_evt[1] - s_e, 31'd0, o_level[1]} !== 128'd0)
         $display("FAIL bounce_counts: got press %0d rel %0d evt %0d lvl %b want 0 0 0 0",
                  n_press[1] - s_p, n_rel[1] - s_r, n_evt[1] - s_e, o_level[1]);
      else n_pass++;
   endtask

   task automatic test_long_hold();
      int s_l, s_rp, s_r, s_e;
      logic rep;
      logic [5:0] exp_v;
      step_tick();
      s_l = n_long[0]; s_rp = n_rep[0]; s_r = n_rel[0]; s_e = n_evt[0];
      i_sw = 3'b110;
      // Press lands on tick 3 (P); release lands on P+17, colliding with a repeat expiry.
      for (int t = 1; t <= 23; t++) begin
         step_tick();
         rep   = (t == 10 || t == 12 || t == 14 || t == 16 || t == 18);
         exp_v = {(t >= 3 && t < 20), (t == 3), (t == 8), rep, (t == 20), (t == 3) | rep};
         n_chk++;
         if ({o_level[0], o_press[0], o_long[0], o_repeat[0], o_release[0], o_event[0]} !== exp_v)
            $display("FAIL long_hold t%0d: got lvl/press/long/rep/rel/evt %b want %b", t,
                     {o_level[0], o_press[0], o_long[0], o_repeat[0], o_release[0], o_event[0]}, exp_v);
         else n_pass++;
         if (t == 17) i_sw = 3'b111;
      end
      n_chk++;
      if ({n_long[0] - s_l, n_rep[0] - s_rp, n_rel[0] - s_r, n_evt[0] - s_e} !== {32'd1, 32'd5, 32'd1, 32'd6})
         $display("FAIL long_counts: got long %0d rep %0d rel %0d evt %0d want 1 5 1 6",
                  n_long[0] - s_l, n_rep[0] - s_rp, n_rel[0] - s_r, n_evt[0] - s_e);
      else n_pass++;
   endtask

   task automatic test_collision();
      int s_l, s_r;
      logic [2:0] exp_v;
      step_tick();
      s_l = n_long[0]; s_r = n_rel[0];
      i_sw = 3'b110;
      // Release driven after P+2 so the debounced fall lands exactly on P+5.
      for (int t = 1; t <= 14; t++) begin
         step_tick();
         exp_v = {(t >= 3 && t < 8), (t == 8), 1'b0};
         n_chk++;
         if ({o_level[0], o_release[0], o_long[0]} !== exp_v)
            $display("FAIL collision t%0d: got lvl/rel/long %b want %b", t,
                     {o_level[0], o_release[0], o_long[0]}, exp_v);
         else n_pass++;
         if (t == 5) i_sw = 3'b111;
      end
      n_chk++;
      if ({n_long[0] - s_l, n_rel[0] - s_r} !== {32'd0, 32'd1})
         $display("FAIL collision_counts: got long %0d rel %0d want 0 1",
                  n_long[0] - s_l, n_rel[0] - s_r);
      else n_pass++;
   endtask

   task automatic test_reset_mid_hold();
      logic [3:0] exp_v;
      step_tick();
      i_sw = 3'b011;
      for (int t = 1; t <= 9; t++) begin
         step_tick();
         exp_v = {(t >= 3), (t == 3), (t == 8), 1'b0};
         n_chk++;
         if ({o_level[2], o_press[2], o_long[2], o_repeat[2]} !== exp_v)
            $display("FAIL prehold t%0d: got lvl/press/long/rep %b want %b", t,
                     {o_level[2], o_press[2], o_long[2], o_repeat[2]}, exp_v);
         else n_pass++;
      end
      rst = 1'b1;
      repeat (2) begin
         step_clk();
         n_chk++;
         if ({o_level, o_press, o_release, o_long, o_repeat, o_event} !== 18'd0)
            $display("FAIL midhold_rst: got %b want 0",
                     {o_level, o_press, o_release, o_long, o_repeat, o_event});
         else n_pass++;
      end
      rst = 1'b0;
      for (int t = 1; t <= 9; t++) begin
         step_tick();
         exp_v = {(t >= 3), (t == 3), (t == 8), 1'b0};
         n_chk++;
         if ({o_level[2], o_press[2], o_long[2], o_repeat[2], o_level[1:0]} !== {exp_v, 2'b00})
            $display("FAIL rehold t%0d: got lvl/press/long/rep/other %b want %b", t,
                     {o_level[2], o_press[2], o_long[2], o_repeat[2], o_level[1:0]}, {exp_v, 2'b00});
         else n_pass++;
      end
      i_sw = 3'b111;
      repeat (4) step_tick();
      n_chk++;
      if (o_level !== 3'b000)
         $display("FAIL midhold_release: got %b want 000", o_level);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_hold();
      test_collision();
      test_reset_mid_hold();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
